// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Each grant carries that requester's baud/parity profile and runs a start/busy handshake with timeout.
module uart_tx_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int MAX_BURST   = 4,
    parameter  int ACK_TIMEOUT = 31,
    localparam int IW          = $clog2(NUM_REQ)
) (
    input  logic                 clkTx,
    input  logic                 resetN,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    input  logic [NUM_REQ-1:0]   reqLast,
    output logic [NUM_REQ-1:0]   reqReady,
    input  logic                 cfgWe,
    input  logic [IW-1:0]        cfgIdx,
    input  logic [2:0]           cfgBaud,
    input  logic [1:0]           cfgParity,
    output logic                 txStart,
    output logic [7:0]           txData,
    output logic [2:0]           txBaudRate,
    output logic [1:0]           txParity,
    input  logic                 txBusy,
    output logic                 grantValid,
    output logic [IW-1:0]        grantId,
    output logic                 ackError
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ROTATE
    } state_e;

    state_e               state_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        owner_q;
    logic [3:0]           burst_q;
    logic [7:0]           timeout_q;
    logic                 last_q;
    logic                 grant_q;
    logic                 start_q;
    logic                 ack_err_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic [7:0]           data_q;
    logic [2:0]           baud_q;
    logic [1:0]           par_q;
    logic [2:0]           prof_baud_q [NUM_REQ];
    logic [1:0]           prof_par_q  [NUM_REQ];

    logic [7:0]           req_byte [NUM_REQ];
    logic                 pick_vld_d;
    logic [IW-1:0]        pick_idx_d;
    logic [IW-1:0]        launch_idx_d;
    logic                 cont_d;
    int                   pick_j;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_byte[g] = reqData[8*g +: 8];
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        pick_j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_j = int'(ptr_q) + k;
            if (pick_j >= NUM_REQ) pick_j = pick_j - NUM_REQ;
            if (reqValid[pick_j[IW-1:0]]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = pick_j[IW-1:0];
            end
        end
    end

    assign launch_idx_d = (state_q == S_ARB) ? pick_idx_d : owner_q;
    assign cont_d       = !last_q && (burst_q < 4'(MAX_BURST)) && reqValid[owner_q];

    // Launch side effects are registered on entry to LAUNCH, so txStart,
    // reqReady and txData are all visible during the LAUNCH cycle itself.
    always_ff @(posedge clkTx or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            burst_q   <= '0;
            timeout_q <= '0;
            last_q    <= 1'b0;
            grant_q   <= 1'b0;
            start_q   <= 1'b0;
            ack_err_q <= 1'b0;
            ready_q   <= '0;
            data_q    <= '0;
            baud_q    <= '0;
            par_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                prof_baud_q[i] <= '0;
                prof_par_q[i]  <= '0;
            end
        end else begin
            start_q <= 1'b0;
            ready_q <= '0;

            if (cfgWe) begin
                ack_err_q <= 1'b0;
                if (int'(cfgIdx) < NUM_REQ) begin
                    prof_baud_q[cfgIdx] <= cfgBaud;
                    prof_par_q[cfgIdx]  <= cfgParity;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (|reqValid) state_q <= S_ARB;
                end

                S_ARB: begin
                    if (pick_vld_d) begin
                        grant_q   <= 1'b1;
                        owner_q   <= pick_idx_d;
                        baud_q    <= prof_baud_q[pick_idx_d];
                        par_q     <= prof_par_q[pick_idx_d];
                        burst_q   <= 4'd1;
                        start_q   <= 1'b1;
                        ready_q   <= NUM_REQ'(1) << launch_idx_d;
                        data_q    <= req_byte[launch_idx_d];
                        last_q    <= reqLast[launch_idx_d];
                        timeout_q <= '0;
                        state_q   <= S_LAUNCH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_LAUNCH: begin
                    state_q <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    if (txBusy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (timeout_q == 8'(ACK_TIMEOUT)) begin
                        ack_err_q <= 1'b1;
                        grant_q   <= 1'b0;
                        state_q   <= S_ROTATE;
                    end else begin
                        timeout_q <= timeout_q + 8'd1;
                    end
                end

                S_WAIT_DONE: begin
                    if (!txBusy) begin
                        if (cont_d) begin
                            burst_q   <= burst_q + 4'd1;
                            start_q   <= 1'b1;
                            ready_q   <= NUM_REQ'(1) << launch_idx_d;
                            data_q    <= req_byte[launch_idx_d];
                            last_q    <= reqLast[launch_idx_d];
                            timeout_q <= '0;
                            state_q   <= S_LAUNCH;
                        end else begin
                            grant_q <= 1'b0;
                            state_q <= S_ROTATE;
                        end
                    end
                end

                S_ROTATE: begin
                    grant_q <= 1'b0;
                    ptr_q   <= (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
                    state_q <= S_ARB;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reqReady   = ready_q;
    assign txStart    = start_q;
    assign txData     = data_q;
    assign txBaudRate = baud_q;
    assign txParity   = par_q;
    assign grantValid = grant_q;
    assign grantId    = owner_q;
    assign ackError   = ack_err_q;

endmodule
